line_track_sequencer: RTL and testbench

- Top-level driving controller for the line-tracking car; produces the 5-bit `mode` and `last_mode` codes consumed by the motor driver.
- Synchronises and debounces three IR line sensors, then runs a mode FSM.
- Handles start countdown, lane correction, junction routing from a programmed route, lost-line recovery and fault timeouts.

---
 rtl/line_track_sequencer_if.sv | 34 +++
 rtl/line_track_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_line_track_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/line_track_sequencer_if.sv
// ---------------------------------------------------------------------------
// line_track_sequencer_if
// Bundles the control, sensor and route inputs and the mode outputs of the
// line-tracking sequencer.
//   start     : single-cycle start pulse (already debounced)
//   stop      : level, forces STOP
//   ir        : raw IR sensors {L,M,R}, 1 = over line, asynchronous
//   route     : programmed route, entry k at [2k+1:2k]
//   mode      : current mode code
//   last_mode : previous distinct mode code
//   junc_cnt  : junctions passed since START
// master drives the inputs (controller/bench side), slave is the sequencer.
// ---------------------------------------------------------------------------
interface line_track_sequencer_if #(
    parameter int MAX_JUNC = 8
);
    logic                    start;
    logic                    stop;
    logic [2:0]              ir;
    logic [2*MAX_JUNC-1:0]   route;
    logic [4:0]              mode;
    logic [4:0]              last_mode;
    logic [3:0]              junc_cnt;

    modport master (
        output start, stop, ir, route,
        input  mode, last_mode, junc_cnt
    );

    modport slave (
        input  start, stop, ir, route,
        output mode, last_mode, junc_cnt
    );
endinterface

// File: rtl/line_track_sequencer.sv
// ---------------------------------------------------------------------------
// line_track_sequencer
// Driving controller of the line-tracking car. Synchronises and debounces the
// three IR sensors, then runs the mode FSM: start countdown, lane correction,
// junction routing from the programmed route, lost-line recovery and fault
// timeouts.
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : line_track_sequencer_if.slave (start, stop, ir, route in;
//         mode, last_mode, junc_cnt out)
// ---------------------------------------------------------------------------
module line_track_sequencer #(
    parameter int COUNT_CYC  = 100000000,
    parameter int DEB_CYC    = 16,
    parameter int CHOOSE_CYC = 20000000,
    parameter int TURN_MIN   = 30000000,
    parameter int TURN_MAX   = 200000000,
    parameter int LOST_CYC   = 50000000,
    parameter int BACK_MAX   = 100000000,
    parameter int MAX_JUNC   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    line_track_sequencer_if.slave bus
);

    typedef enum logic [4:0] {
        M_IDLE         = 5'd0,
        M_START        = 5'd1,
        M_COUNT        = 5'd2,
        M_STRAIGHT     = 5'd3,
        M_CHOOSE       = 5'd4,
        M_LEFT         = 5'd5,
        M_RIGHT        = 5'd6,
        M_BACK         = 5'd7,
        M_LITTLE_LEFT  = 5'd8,
        M_LITTLE_RIGHT = 5'd9,
        M_FINISH       = 5'd29,
        M_STOP         = 5'd30,
        M_ERROR        = 5'd31
    } mode_t;

    localparam logic [27:0] COUNT_LAST  = 28'(COUNT_CYC - 1);
    localparam logic [27:0] DEB_N       = 28'(DEB_CYC);
    localparam logic [27:0] CHOOSE_LAST = 28'(CHOOSE_CYC - 1);
    localparam logic [27:0] TURN_LO     = 28'(TURN_MIN);
    localparam logic [27:0] TURN_LAST   = 28'(TURN_MAX - 1);
    localparam logic [27:0] LOST_LAST   = 28'(LOST_CYC - 1);
    localparam logic [27:0] BACK_LAST   = 28'(BACK_MAX - 1);
    localparam logic [3:0]  JUNC_MAX    = 4'(MAX_JUNC);

    mode_t       state, next_state, last_state;
    logic [3:0]  junc_cnt;
    logic [27:0] state_tmr, lost_tmr;
    logic        take_route;
    logic        lost_active;
    logic [1:0]  entry;

    // ---------------- sensor path ----------------
    logic [2:0]  sync1, sync2, sync3, filt;
    logic [27:0] deb_cnt, deb_run;

    // deb_run = consecutive cycles, including this one, that sync2 has held
    // its current value; sync3 is sync2 one cycle late.
    always_comb begin
        deb_run = 28'd1;
        if (sync2 == sync3)
            deb_run = (deb_cnt == '1) ? deb_cnt : deb_cnt + 28'd1;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 3'b000;
            sync2   <= 3'b000;
            sync3   <= 3'b000;
            deb_cnt <= '0;
            filt    <= 3'b000;
        end else begin
            sync1   <= bus.ir;
            sync2   <= sync1;
            sync3   <= sync2;
            deb_cnt <= (deb_run >= DEB_N) ? DEB_N : deb_run;
            if (deb_run >= DEB_N)
                filt <= sync2;
        end
    end

    // Route entry selected by the current junction count.
    always_comb begin
        entry = 2'b00;
        for (int k = 0; k < MAX_JUNC; k++)
            if (junc_cnt == k[3:0])
                entry = bus.route[2*k +: 2];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= M_IDLE;
            last_state <= M_IDLE;
            junc_cnt   <= '0;
            state_tmr  <= '0;
            lost_tmr   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                last_state <= state;
                state_tmr  <= '0;
            end else if (state_tmr != '1) begin
                state_tmr  <= state_tmr + 28'd1;
            end

            if (!lost_active)
                lost_tmr <= '0;
            else if (lost_tmr != '1)
                lost_tmr <= lost_tmr + 28'd1;

            if (state == M_START)
                junc_cnt <= '0;
            else if (take_route && junc_cnt != JUNC_MAX)
                junc_cnt <= junc_cnt + 4'd1;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        take_route = 1'b0;
        case (state)
            M_IDLE:  if (bus.start) next_state = M_START;
            M_START: next_state = M_COUNT;
            M_COUNT: if (state_tmr == COUNT_LAST) next_state = M_STRAIGHT;

            M_STRAIGHT, M_LITTLE_LEFT, M_LITTLE_RIGHT: begin
                if (filt == 3'b111)
                    next_state = M_CHOOSE;
                else if (lost_tmr == LOST_LAST)
                    next_state = M_BACK;
                else begin
                    case (filt)
                        3'b010:         next_state = M_STRAIGHT;
                        3'b100, 3'b110: next_state = M_LITTLE_LEFT;
                        3'b001, 3'b011: next_state = M_LITTLE_RIGHT;
                        default:        next_state = state;  // 000 / 101
                    endcase
                end
            end

            M_CHOOSE: begin
                if (state_tmr == CHOOSE_LAST) begin
                    if (junc_cnt == JUNC_MAX)
                        next_state = M_FINISH;
                    else begin
                        take_route = 1'b1;
                        case (entry)
                            2'b00:   next_state = M_STRAIGHT;
                            2'b01:   next_state = M_LEFT;
                            2'b10:   next_state = M_RIGHT;
                            default: next_state = M_FINISH;
                        endcase
                    end
                end
            end

            M_LEFT, M_RIGHT: begin
                if (state_tmr >= TURN_LO && filt == 3'b010)
                    next_state = M_STRAIGHT;
                else if (state_tmr == TURN_LAST)
                    next_state = M_ERROR;
            end

            M_BACK: begin
                if (filt != 3'b000)
                    next_state = M_STRAIGHT;
                else if (state_tmr == BACK_LAST)
                    next_state = M_ERROR;
            end

            M_FINISH, M_STOP, M_ERROR: if (bus.start) next_state = M_START;

            default: next_state = M_IDLE;
        endcase

        // stop outranks everything, including a route decision in this cycle.
        if (bus.stop && state != M_IDLE && state != M_STOP) begin
            next_state = M_STOP;
            take_route = 1'b0;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.mode      = state;
        bus.last_mode = last_state;
        bus.junc_cnt  = junc_cnt;
        lost_active   = (filt == 3'b000) &&
                        (state == M_STRAIGHT || state == M_LITTLE_LEFT ||
                         state == M_LITTLE_RIGHT);
    end

endmodule

// File: tb/tb_line_track_sequencer.sv
// ---------------------------------------------------------------------------
// tb_line_track_sequencer
// Directed bench for line_track_sequencer with small timing parameters.
// Expected mode/last_mode/junc_cnt values are hand-computed from the cycle
// behaviour: ir reaches filt 4 cycles after a change (2 sync + 2 debounce).
// ---------------------------------------------------------------------------
module tb_line_track_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    line_track_sequencer_if #(.MAX_JUNC(2)) bus ();

    line_track_sequencer #(
        .COUNT_CYC (10),
        .DEB_CYC   (2),
        .CHOOSE_CYC(4),
        .TURN_MIN  (5),
        .TURN_MAX  (20),
        .LOST_CYC  (6),
        .BACK_MAX  (8),
        .MAX_JUNC  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_mode(input string tag, input logic [4:0] exp);
        check(tag, 32'(bus.mode), 32'(exp));
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ir    = 3'b010;
        bus.route = 4'b0110;   // entry0 = right, entry1 = left

        // Reset state
        step(2);
        chk_mode("reset_mode", 5'd0);
        check("reset_last", 32'(bus.last_mode), 32'd0);
        check("reset_junc", 32'(bus.junc_cnt), 32'd0);
        rst = 1'b0;
        step(3);
        chk_mode("idle_no_start", 5'd0);

        // Start and countdown
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk_mode("start", 5'd1);
        check("start_last", 32'(bus.last_mode), 32'd0);
        step(1);
        chk_mode("count_entry", 5'd2);
        check("count_last", 32'(bus.last_mode), 32'd1);
        step(9);
        chk_mode("count_end", 5'd2);
        step(1);
        chk_mode("straight", 5'd3);
        check("straight_last", 32'(bus.last_mode), 32'd2);

        // Lane correction
        bus.ir = 3'b110;
        step(4); chk_mode("ll_latency", 5'd3);
        step(1); chk_mode("little_left", 5'd8);
        check("ll_last", 32'(bus.last_mode), 32'd3);
        bus.ir = 3'b010;
        step(4); chk_mode("ll_hold", 5'd8);
        step(1); chk_mode("ll_recover", 5'd3);

        // One-cycle glitch is filtered
        bus.ir = 3'b100; step(1); bus.ir = 3'b010;
        step(8);
        chk_mode("glitch_mode", 5'd3);
        check("glitch_last", 32'(bus.last_mode), 32'd8);

        // First junction -> RIGHT, turn honoured at state_tmr == 5
        bus.ir = 3'b111;
        step(4); chk_mode("j1_latency", 5'd3);
        step(1); chk_mode("j1_choose", 5'd4);
        step(3); chk_mode("j1_choose_end", 5'd4);
        check("j1_junc_before", 32'(bus.junc_cnt), 32'd0);
        step(1); chk_mode("j1_right", 5'd6);
        check("j1_junc", 32'(bus.junc_cnt), 32'd1);
        check("j1_last", 32'(bus.last_mode), 32'd4);
        bus.ir = 3'b010;
        step(5); chk_mode("turn_min_hold", 5'd6);
        step(1); chk_mode("turn_exit", 5'd3);

        // Second junction -> LEFT
        bus.ir = 3'b111;
        step(5); chk_mode("j2_choose", 5'd4);
        step(4); chk_mode("j2_left", 5'd5);
        check("j2_junc", 32'(bus.junc_cnt), 32'd2);
        bus.ir = 3'b010;
        step(5); chk_mode("j2_turn_hold", 5'd5);
        step(1); chk_mode("j2_turn_exit", 5'd3);

        // Third junction -> route exhausted -> FINISH, no increment
        bus.ir = 3'b111;
        step(5); chk_mode("j3_choose", 5'd4);
        step(4); chk_mode("j3_finish", 5'd29);
        check("j3_junc_sat", 32'(bus.junc_cnt), 32'd2);
        check("j3_last", 32'(bus.last_mode), 32'd4);
        step(3); chk_mode("finish_hold", 5'd29);

        // Restart, lose the line -> BACK -> ERROR
        bus.ir = 3'b010;
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk_mode("restart", 5'd1);
        step(1);
        check("restart_junc_clr", 32'(bus.junc_cnt), 32'd0);
        step(10); chk_mode("restart_straight", 5'd3);
        bus.ir = 3'b000;
        step(9); chk_mode("lost_hold", 5'd3);
        step(1); chk_mode("back", 5'd7);
        check("back_last", 32'(bus.last_mode), 32'd3);
        step(7); chk_mode("back_hold", 5'd7);
        step(1); chk_mode("error", 5'd31);
        check("error_last", 32'(bus.last_mode), 32'd7);
        step(2); chk_mode("error_hold", 5'd31);

        // From ERROR: start, route entry0 = left, then stop+start in LEFT
        bus.route = 4'b0001;
        bus.ir    = 3'b111;
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk_mode("err_restart", 5'd1);
        step(11); chk_mode("s_straight", 5'd3);
        step(1);  chk_mode("s_choose", 5'd4);
        step(4);  chk_mode("s_left", 5'd5);
        step(2);
        bus.stop = 1'b1; bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk_mode("stop_wins", 5'd30);
        check("stop_last", 32'(bus.last_mode), 32'd5);
        step(2); chk_mode("stop_hold", 5'd30);
        bus.stop = 1'b0;
        step(2); chk_mode("stop_released", 5'd30);
        bus.start = 1'b1; step(1); bus.start = 1'b0;
        chk_mode("stop_restart", 5'd1);
        check("stop_restart_last", 32'(bus.last_mode), 32'd30);

        // RIGHT, then asynchronous reset mid-turn
        bus.route = 4'b0010;
        step(12); chk_mode("r_choose", 5'd4);
        step(4);  chk_mode("r_right", 5'd6);
        check("r_junc", 32'(bus.junc_cnt), 32'd1);
        step(2);
        #2 rst = 1'b1;
        #1;
        chk_mode("async_rst_mode", 5'd0);
        check("async_rst_last", 32'(bus.last_mode), 32'd0);
        check("async_rst_junc", 32'(bus.junc_cnt), 32'd0);
        step(2);
        rst = 1'b0;
        step(30);
        chk_mode("post_rst_idle", 5'd0);
        check("post_rst_junc", 32'(bus.junc_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
